wb_regfile: RTL
===============

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-low reset; low clears state immediately.
REQ-003 wb_RegWrite  in  1  register write request from MEM/WB register.
REQ-004 wb_Jal  in  1  jal writeback; overrides destination and data selection.
REQ-005 wb_RegDST  in  1  1 = destination rd, 0 = destination rt.
REQ-006 wb_MemtoReg  in  1  1 = write data from memory, 0 = from ALU.
REQ-007 wb_ReadData  in  32  memory load data.
REQ-008 wb_ALUResult  in  32  ALU result.
REQ-009 wb_rt_addr / wb_rd_addr  in  5 each  candidate destinations.
REQ-010 wb_pc  in  32  PC of the retiring instruction.
REQ-011 rs_addr / rt_addr  in  5 each  decode-stage read addresses.
REQ-012 rs_data / rt_data  out  32 each  read port data.
REQ-013 wb_we / wb_waddr / wb_wdata  out  1/5/32  resolved write, exported to the forwarding unit.
REQ-014 wb_retire_cnt  out  16  count of retired register-writing instructions.

Function
REQ-015 wb_waddr SHALL be 31 when wb_Jal=1, else wb_rd_addr when wb_RegDST=1, else wb_rt_addr.
REQ-016 wb_wdata SHALL be wb_pc+4 (modulo 2^32) when wb_Jal=1, else wb_ReadData when wb_MemtoReg=1, else wb_ALUResult.
REQ-017 wb_we SHALL equal wb_RegWrite OR wb_Jal; wb_we/wb_waddr/wb_wdata are combinational, zero-latency.
REQ-018 The block SHALL hold 32 x 32-bit registers; on a rising edge with wb_we=1 and wb_waddr!=0, register[wb_waddr] <= wb_wdata.
REQ-019 Register 0 SHALL read 0 at all times; writes to it are discarded.
REQ-020 rs_data/rt_data SHALL be combinational reads of the register array (subject to REQ-027/028).
REQ-021 wb_retire_cnt SHALL increment by 1 on each rising edge with wb_we=1, including writes to register 0.
REQ-022 wb_retire_cnt SHALL wrap from 0xFFFF to 0x0000 without a flag.
REQ-023 Simultaneous read and write of the same nonzero address SHALL update the array at the edge; read value in that cycle per Configuration.

Reset
REQ-024 While reset=0, all 32 registers SHALL read 0 and wb_retire_cnt SHALL be 0, asynchronously to clk.
REQ-025 A write edge coinciding with reset=0 SHALL be ignored; the first write takes effect on the first rising edge after reset returns to 1.
REQ-026 wb_we/wb_waddr/wb_wdata SHALL remain a function of inputs during reset; the forwarding unit gates them.

Configuration
REQ-027 With WB_BYPASS_EN defined: when wb_we=1, wb_waddr!=0 and a read address equals wb_waddr, that read port SHALL return wb_wdata in the same cycle.
REQ-028 Without WB_BYPASS_EN: read ports SHALL return the stored value (pre-write) in that cycle; the forwarding unit covers the hazard.

Verification
REQ-029 Reset low, write requests applied -> all reads 0, wb_retire_cnt=0; release, write r5=0x1234 (RegDST=1, rd=5, MemtoReg=0) -> next cycle rs_addr=5 gives 0x00001234, cnt=1.
REQ-030 wb_Jal=1, wb_pc=0x00400010, wb_RegWrite=0 -> wb_we=1, wb_waddr=31, wb_wdata=0x00400014; r31 reads 0x00400014 after the edge.
REQ-031 Write r0=0xFFFFFFFF via rt path (RegDST=0, rt=0) -> rs_addr=0 reads 0; wb_retire_cnt increments.
REQ-032 Same-cycle write r7=0xA5A5A5A5 and rt_addr=7 (r7 previously 0x11) -> rt_data=0xA5A5A5A5 with WB_BYPASS_EN, 0x00000011 without; both 0xA5A5A5A5 next cycle.
REQ-033 65536 consecutive write cycles from reset -> wb_retire_cnt returns to 0x0000; one more -> 0x0001.
REQ-034 Assert reset mid-sequence between edges with r3=0x55 -> r3 and wb_retire_cnt read 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/wb_regfile_if.sv
// Writeback/read-port bundle between the MEM/WB stage, decode and the register file.
interface wb_regfile_if;
   logic        wb_RegWrite;
   logic        wb_Jal;
   logic        wb_RegDST;
   logic        wb_MemtoReg;
   logic [31:0] wb_ReadData;
   logic [31:0] wb_ALUResult;
   logic [4:0]  wb_rt_addr;
   logic [4:0]  wb_rd_addr;
   logic [31:0] wb_pc;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        wb_we;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata;
   logic [15:0] wb_retire_cnt;

   modport master (
      output wb_RegWrite, wb_Jal, wb_RegDST, wb_MemtoReg,
      output wb_ReadData, wb_ALUResult, wb_rt_addr, wb_rd_addr, wb_pc,
      output rs_addr, rt_addr,
      input  rs_data, rt_data, wb_we, wb_waddr, wb_wdata, wb_retire_cnt
   );

   modport slave (
      input  wb_RegWrite, wb_Jal, wb_RegDST, wb_MemtoReg,
      input  wb_ReadData, wb_ALUResult, wb_rt_addr, wb_rd_addr, wb_pc,
      input  rs_addr, rt_addr,
      output rs_data, rt_data, wb_we, wb_waddr, wb_wdata, wb_retire_cnt
   );
endinterface

// File: rtl/wb_regfile.sv
// Writeback-stage register file: resolves the write, holds 32x32 registers, counts retirements.
// Optional WB_BYPASS_EN: read ports return the in-flight write data in the same cycle.
module wb_regfile (
   input  logic         clk,
   input  logic         reset,
   wb_regfile_if.slave  bus
);

   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        wr_en;

   logic [31:0] regs_q [32];
   logic [31:0] regs_d [32];
   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   logic [31:0] rs_data;
   logic [31:0] rt_data;

   // jal takes priority over both the destination and data muxes
   always_comb begin
      we    = bus.wb_RegWrite | bus.wb_Jal;
      waddr = bus.wb_RegDST ? bus.wb_rd_addr : bus.wb_rt_addr;
      wdata = bus.wb_MemtoReg ? bus.wb_ReadData : bus.wb_ALUResult;
      if (bus.wb_Jal) begin
         waddr = 5'd31;
         wdata = bus.wb_pc + 32'd4;
      end
      wr_en = we && (waddr != 5'd0);
   end

   always_comb begin
      regs_d = regs_q;
      if (wr_en) begin
         regs_d[waddr] = wdata;
      end
      regs_d[0] = '0;
   end

   // r0 writes still retire, so the counter follows we rather than wr_en
   always_comb begin
      cnt_d = cnt_q;
      if (we) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         regs_q <= '{default: '0};
         cnt_q  <= '0;
      end else begin
         regs_q <= regs_d;
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      rs_data = regs_q[bus.rs_addr];
      rt_data = regs_q[bus.rt_addr];
`ifdef WB_BYPASS_EN
      if (wr_en && (bus.rs_addr == waddr)) begin
         rs_data = wdata;
      end
      if (wr_en && (bus.rt_addr == waddr)) begin
         rt_data = wdata;
      end
`else
      // stored value only; the forwarding unit resolves the same-cycle hazard
`endif
   end

   assign bus.rs_data       = rs_data;
   assign bus.rt_data       = rt_data;
   assign bus.wb_we         = we;
   assign bus.wb_waddr      = waddr;
   assign bus.wb_wdata      = wdata;
   assign bus.wb_retire_cnt = cnt_q;

endmodule
